// File: rtl/fpu_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module : fpu_sched_pkg
// Brief  : Opcode encodings and scheduler state type for fpu_rr_scheduler.
// Rev    : 1.0
// ============================================================================
package fpu_sched_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // The unit only implements add and div; both unsupported codes have bit 0 set.
    function automatic logic op_illegal(input logic [1:0] op);
        return op[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_rr_scheduler_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way round-robin arbiter; the requester not granted last wins.
// Rev    : 1.0
// ============================================================================
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (last) begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end else begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module : fpu_rr_scheduler
// Brief  : Shares one add/div unit between two requesters, one op in flight,
//          with timeout and a single tagged response channel.
// Rev    : 1.0
// ============================================================================
module fpu_rr_scheduler
    import fpu_sched_pkg::*;
#(
    parameter int W        = 32,
    parameter int TO_CYC   = 64,
    parameter int MIN_WAIT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [2*W-1:0] req_a,
    input  logic [2*W-1:0] req_b,
    input  logic [3:0]     req_op,
    output logic           unit_start,
    output logic [W-1:0]   unit_a,
    output logic [W-1:0]   unit_b,
    output logic [1:0]     unit_op,
    input  logic [W-1:0]   unit_result,
    input  logic           unit_done,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [W-1:0]   rsp_data,
    output logic           rsp_err,
    output logic           busy
);

    localparam int CW = $clog2(TO_CYC) + 1;
    localparam logic [CW-1:0] C_CNT_LAST = CW'(TO_CYC - 1);
    localparam logic [CW-1:0] C_CNT_MIN  = CW'(MIN_WAIT);

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, data_q, data_d;
    logic [1:0]      op_q, op_d;
    logic            id_q, id_d, err_q, err_d, last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      w_gnt;
    logic [1:0]      w_req_op;

    // Masking the requests outside IDLE makes req_ready zero there for free.
    rr_arb2 u_arb (
        .req  (req_valid & {2{state_q == ST_IDLE}}),
        .last (last_q),
        .gnt  (w_gnt)
    );

    assign w_req_op = w_gnt[1] ? req_op[3:2] : req_op[1:0];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        id_d    = id_q;
        data_d  = data_q;
        err_d   = err_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|w_gnt) begin
                    id_d = w_gnt[1];
                    a_d  = w_gnt[1] ? req_a[W +: W] : req_a[0 +: W];
                    b_d  = w_gnt[1] ? req_b[W +: W] : req_b[0 +: W];
                    op_d = w_req_op;
                    if (op_illegal(w_req_op)) begin
                        err_d   = 1'b1;
                        data_d  = '0;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion is checked before the timeout so a late done still wins.
                if (unit_done && (cnt_q >= C_CNT_MIN)) begin
                    data_d  = unit_result;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == C_CNT_LAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    last_d  = id_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            id_q    <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            id_q    <= id_d;
            data_q  <= data_d;
            err_q   <= err_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready  = w_gnt;
    assign unit_start = (state_q == ST_ISSUE);
    assign unit_a     = a_q;
    assign unit_b     = b_q;
    assign unit_op    = op_q;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_id     = id_q;
    assign rsp_data   = data_q;
    assign rsp_err    = err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fpu_rr_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_fpu_rr_scheduler
// Brief  : Directed self-checking bench for fpu_rr_scheduler with a simple
//          add/div unit stand-in whose done latency is adjustable.
// Rev    : 1.0
// ============================================================================
module tb_fpu_rr_scheduler;

    localparam int W = 32;
    localparam logic [1:0] C_ADD = 2'b00;
    localparam logic [1:0] C_MUL = 2'b01;
    localparam logic [1:0] C_DIV = 2'b10;
    localparam logic [1:0] C_RSV = 2'b11;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [1:0]     req_ready;
    logic           v0 = 1'b0, v1 = 1'b0;
    logic [W-1:0]   a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic [1:0]     op0 = '0, op1 = '0;
    logic           unit_start, unit_done;
    logic [W-1:0]   unit_a, unit_b, unit_result, rsp_data;
    logic [1:0]     unit_op;
    logic           rsp_valid, rsp_ready, rsp_id, rsp_err, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_starts = 0;
    int done_dly = 0;
    bit done_en  = 1'b1;

    fpu_rr_scheduler #(.W(W), .TO_CYC(64), .MIN_WAIT(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   ({v1, v0}),
        .req_ready   (req_ready),
        .req_a       ({a1, a0}),
        .req_b       ({b1, b0}),
        .req_op      ({op1, op0}),
        .unit_start  (unit_start),
        .unit_a      (unit_a),
        .unit_b      (unit_b),
        .unit_op     (unit_op),
        .unit_result (unit_result),
        .unit_done   (unit_done),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (unit_start) n_starts++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Unit stand-in: done is held until the response appears so MIN_WAIT masking can be seen.
    initial begin
        unit_done   = 1'b0;
        unit_result = '0;
        forever begin
            @(negedge clk);
            if (unit_start && done_en) begin
                repeat (done_dly) @(negedge clk);
                if (unit_op == C_DIV) unit_result = (unit_b == 0) ? '0 : unit_a / unit_b;
                else                  unit_result = unit_a + unit_b;
                unit_done = 1'b1;
                for (int k = 0; k < 200; k++) begin
                    if (rsp_valid || rst) break;
                    @(negedge clk);
                end
                unit_done = 1'b0;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] op);
        bit granted = 1'b0;
        @(negedge clk);
        if (id == 0) begin a0 = a; b0 = b; op0 = op; v0 = 1'b1; end
        else         begin a1 = a; b1 = b; op1 = op; v1 = 1'b1; end
        for (int k = 0; k < 300; k++) begin
            #1;
            if (req_ready[id]) begin granted = 1'b1; break; end
            @(negedge clk);
        end
        if (!granted) chk($sformatf("grant_timeout_id%0d", id), 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (id == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic id, input logic [W-1:0] data,
                            input logic err);
        bit seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1'b1; break; end
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_id"},   32'(rsp_id),  32'(id));
            chk({tag, "_data"}, rsp_data,     data);
            chk({tag, "_err"},  32'(rsp_err), 32'(err));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  n0, n;
        bit  ok;
        rsp_ready = 1'b1;

        // 1: reset values, then a single add
        repeat (2) @(negedge clk);
        chk("rst_req_ready",  32'(req_ready),  32'd0);
        chk("rst_unit_start", 32'(unit_start), 32'd0);
        chk("rst_unit_a",     unit_a,          32'd0);
        chk("rst_unit_b",     unit_b,          32'd0);
        chk("rst_unit_op",    32'(unit_op),    32'd0);
        chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
        chk("rst_rsp_id",     32'(rsp_id),     32'd0);
        chk("rst_rsp_data",   rsp_data,        32'd0);
        chk("rst_rsp_err",    32'(rsp_err),    32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        rst = 1'b0;
        do_req(0, 32'd5, 32'd7, C_ADD);
        wait_rsp("t1", 1'b0, 32'd12, 1'b0);

        // 2: both request; req0 re-requests at once but req1 must be served before it
        do_reset();
        fork
            begin
                do_req(0, 32'd1, 32'd1, C_ADD);
                do_req(0, 32'd3, 32'd3, C_ADD);
            end
            do_req(1, 32'd2, 32'd2, C_ADD);
            begin
                wait_rsp("t2_a", 1'b0, 32'd2, 1'b0);
                wait_rsp("t2_b", 1'b1, 32'd4, 1'b0);
                wait_rsp("t2_c", 1'b0, 32'd6, 1'b0);
            end
        join

        // 3: slow divide; operands must stay put for the whole wait
        done_dly = 20;
        n0 = n_starts;
        do_req(1, 32'd100, 32'd4, C_DIV);
        ok = 1'b1;
        begin : t3_wait
            bit seen = 1'b0;
            for (int k = 0; k < 200; k++) begin
                @(negedge clk);
                if (unit_a != 32'd100 || unit_b != 32'd4 || unit_op != C_DIV) ok = 1'b0;
                if (rsp_valid) begin seen = 1'b1; break; end
            end
            chk("t3_seen", 32'(seen), 32'd1);
        end
        chk("t3_stable", 32'(ok),           32'd1);
        chk("t3_starts", 32'(n_starts - n0), 32'd1);
        chk("t3_id",     32'(rsp_id),       32'd1);
        chk("t3_data",   rsp_data,          32'd25);
        chk("t3_err",    32'(rsp_err),      32'd0);
        @(posedge clk); #1;
        done_dly = 0;

        // 4: unsupported opcodes are rejected without touching the unit
        n0 = n_starts;
        do_req(0, 32'd3, 32'd3, C_MUL);
        @(negedge clk);
        chk("t4_mul_valid", 32'(rsp_valid), 32'd1);
        chk("t4_mul_err",   32'(rsp_err),   32'd1);
        chk("t4_mul_data",  rsp_data,       32'd0);
        @(posedge clk); #1;
        do_req(1, 32'd9, 32'd9, C_RSV);
        @(negedge clk);
        chk("t4_rsv_valid", 32'(rsp_valid), 32'd1);
        chk("t4_rsv_err",   32'(rsp_err),   32'd1);
        chk("t4_rsv_id",    32'(rsp_id),    32'd1);
        @(posedge clk); #1;
        chk("t4_starts", 32'(n_starts - n0), 32'd0);

        // 5: unit never answers -> timeout 64 cycles after WAIT entry
        done_en = 1'b0;
        do_req(0, 32'd50, 32'd5, C_DIV);
        @(posedge clk);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            n++;
            #1;
            if (rsp_valid) break;
        end
        chk("t5_cycles", 32'(n),         32'd64);
        chk("t5_err",    32'(rsp_err),   32'd1);
        chk("t5_data",   rsp_data,       32'd0);
        chk("t5_id",     32'(rsp_id),    32'd0);
        @(posedge clk); #1;
        chk("t5_busy",   32'(busy),      32'd0);

        // 6: back-pressure holds the response and blocks new grants
        done_en   = 1'b1;
        rsp_ready = 1'b0;
        do_req(0, 32'd9, 32'd8, C_ADD);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        a1 = 32'd1; b1 = 32'd1; op1 = C_ADD; v1 = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data != 32'd17 || rsp_id != 1'b0 || rsp_err || req_ready != 2'b00)
                ok = 1'b0;
        end
        chk("t6_hold", 32'(ok),  32'd1);
        chk("t6_data", rsp_data, 32'd17);
        v1 = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;

        // reset during WAIT drops the op with no response
        done_en = 1'b0;
        do_req(1, 32'd7, 32'd7, C_ADD);
        repeat (5) @(negedge clk);
        chk("t6_busy_pre", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(rsp_valid), 32'd0);
        chk("t6_rst_busy",  32'(busy),      32'd0);
        chk("t6_rst_a",     unit_a,         32'd0);
        @(negedge clk);
        rst = 1'b0;
        ok = 1'b1;
        repeat (80) begin
            @(negedge clk);
            if (rsp_valid || busy) ok = 1'b0;
        end
        chk("t6_no_stale", 32'(ok), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
